// File: rtl/pattern_match_detector.sv
// Masked pattern detector: parallel word compare or serial sequence detect.
// Ports: clk, rst_n (async low), in_valid, in_data[W], mode (0 par / 1 ser),
//        cfg_pattern[W], cfg_mask[W], clear -> match, match_count[CNT_W], sat.
module pattern_match_detector #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic             mode,
    input  logic [W-1:0]     cfg_pattern,
    input  logic [W-1:0]     cfg_mask,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             sat
);

    localparam int FW = $clog2(W + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(W - 1);

    typedef enum logic {
        S_FILL,
        S_ARMED
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_window;
    logic [FW-1:0]    r_fill;
    logic             r_mode_q;
    logic             r_match;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;

    logic             w_mode_chg;
    state_t           w_state_base;
    logic [W-1:0]     w_win_base;
    logic [FW-1:0]    w_fill_base;
    state_t           w_state_next;
    logic [W-1:0]     w_win_next;
    logic [FW-1:0]    w_fill_next;
    logic [W-1:0]     w_x;
    logic             w_qual;
    logic             w_hit;

    // A mode change restarts serial detection; a sample on that same
    // cycle then becomes the first bit of the fresh fill.
    always_comb begin
        w_mode_chg   = (mode != r_mode_q);
        w_state_base = w_mode_chg ? S_FILL : r_state;
        w_win_base   = w_mode_chg ? '0 : r_window;
        w_fill_base  = w_mode_chg ? '0 : r_fill;
        w_state_next = w_state_base;
        w_win_next   = w_win_base;
        w_fill_next  = w_fill_base;
        w_x          = in_data;
        w_qual       = 1'b0;
        if (in_valid) begin
            if (mode) begin
                w_win_next = {w_win_base[W-2:0], in_data[0]};
                w_x        = w_win_next;
                unique case (w_state_base)
                    S_FILL: begin
                        w_fill_next = w_fill_base + 1'b1;
                        // the W-th bit completes the window and counts
                        if (w_fill_base == FILL_LAST) begin
                            w_state_next = S_ARMED;
                            w_qual       = 1'b1;
                        end
                    end
                    S_ARMED: w_qual = 1'b1;
                    default: w_qual = 1'b0;
                endcase
            end else begin
                w_qual = 1'b1;
            end
        end
        w_hit = w_qual && (((w_x ^ cfg_pattern) & cfg_mask) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FILL;
            r_window <= '0;
            r_fill   <= '0;
            r_mode_q <= 1'b0;
            r_match  <= 1'b0;
            r_count  <= '0;
            r_sat    <= 1'b0;
        end else if (clear) begin
            r_state  <= S_FILL;
            r_window <= '0;
            r_fill   <= '0;
            r_mode_q <= mode;
            r_match  <= 1'b0;
            r_count  <= '0;
            r_sat    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_window <= w_win_next;
            r_fill   <= w_fill_next;
            r_mode_q <= mode;
            r_match  <= w_hit;
            if (w_hit) begin
                if (r_count == {CNT_W{1'b1}}) begin
                    r_sat <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign match       = r_match;
    assign match_count = r_count;
    assign sat         = r_sat;

endmodule

// File: tb/tb_pattern_match_detector.sv
// Bench for pattern_match_detector: history-queue model checked every
// cycle on two instances (CNT_W=8 and CNT_W=2) plus literal expectations.
module tb_pattern_match_detector;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       mode;
    logic [3:0] pat;
    logic [3:0] mask;
    logic       clear;

    logic       match_a;
    logic [7:0] count_a;
    logic       sat_a;
    logic       match_b;
    logic [1:0] count_b;
    logic       sat_b;

    int total = 0;
    int bad   = 0;

    pattern_match_detector #(.W(4), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .mode(mode), .cfg_pattern(pat), .cfg_mask(mask), .clear(clear),
        .match(match_a), .match_count(count_a), .sat(sat_a)
    );

    pattern_match_detector #(.W(4), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .mode(mode), .cfg_pattern(pat), .cfg_mask(mask), .clear(clear),
        .match(match_b), .match_count(count_b), .sat(sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: total hit count since reset/clear, plus the serial bit
    // history since the last restart; a serial hit needs W bits of history.
    int  hits      = 0;
    bit  m_match   = 0;
    bit  prev_mode = 0;
    bit  hist[$];

    always @(posedge clk or negedge rst_n) begin
        bit [3:0] x;
        bit       q;
        if (!rst_n) begin
            hits      = 0;
            m_match   = 0;
            prev_mode = 0;
            hist.delete();
        end else begin
            m_match = 0;
            if (clear) begin
                hits = 0;
                hist.delete();
            end else begin
                if (mode != prev_mode) hist.delete();
                q = 0;
                x = in_data;
                if (in_valid) begin
                    if (!mode) begin
                        q = 1;
                    end else begin
                        hist.push_back(in_data[0]);
                        if (hist.size() > 4) void'(hist.pop_front());
                        if (hist.size() == 4) begin
                            q = 1;
                            for (int i = 0; i < 4; i++) x[3-i] = hist[i];
                        end
                    end
                end
                if (q && (((x ^ pat) & mask) == 4'b0000)) begin
                    hits++;
                    m_match = 1;
                end
            end
            prev_mode = mode;
        end
    end

    always @(negedge clk) begin
        chk("cmp_match_a", match_a, m_match);
        chk("cmp_count_a", count_a, (hits > 255) ? 255 : hits);
        chk("cmp_sat_a",   sat_a,   hits > 255);
        chk("cmp_match_b", match_b, m_match);
        chk("cmp_count_b", count_b, (hits > 3) ? 3 : hits);
        chk("cmp_sat_b",   sat_b,   hits > 3);
    end

    task automatic send(input logic v, input logic [3:0] d,
                        input logic m, input logic c);
        in_valid = v;
        in_data  = d;
        mode     = m;
        clear    = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        clear    = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] seq8;
    logic [5:0] seq6;
    logic [3:0] seq4;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0;
        clear = 1'b0; pat = 4'b1100; mask = 4'b1111;
        repeat (2) @(negedge clk);
        chk("rst_match", match_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_sat",   sat_a,   0);
        rst_n = 1'b1;

        send(1, 4'b1100, 0, 0);
        chk("par_hit_match", match_a, 1);
        chk("par_hit_count", count_a, 1);
        send(1, 4'b1101, 0, 0);
        chk("par_miss_match", match_a, 0);
        chk("par_miss_count", count_a, 1);
        idle(1);
        chk("idle_match", match_a, 0);

        mask = 4'b1100;
        send(1, 4'b1111, 0, 0);
        chk("mask_hit", match_a, 1);
        send(1, 4'b0111, 0, 0);
        chk("mask_miss", match_a, 0);
        mask = 4'b1111;

        send(0, 4'b0000, 0, 1);
        chk("clear_count", count_a, 0);

        seq8 = 8'b11001100;
        for (int i = 0; i < 8; i++) begin
            send(1, {3'b000, seq8[7-i]}, 1, 0);
            chk("ser_match", match_a, (i == 3 || i == 7));
        end
        chk("ser_count", count_a, 2);

        pat = 4'b1010;
        send(0, 4'b0000, 1, 1);
        seq6 = 6'b101010;
        for (int i = 0; i < 6; i++) begin
            send(1, {3'b000, seq6[5-i]}, 1, 0);
            chk("ovl_match", match_a, (i == 3 || i == 5));
        end
        chk("ovl_count", count_a, 2);

        pat = 4'b1100;
        send(0, 4'b0000, 1, 1);
        send(1, 4'b0001, 1, 0);
        send(1, 4'b0001, 1, 0);
        idle(3);
        chk("hold_match", match_a, 0);
        send(1, 4'b0000, 1, 0);
        chk("hold_early", match_a, 0);
        send(1, 4'b0000, 1, 0);
        chk("hold_hit", match_a, 1);

        send(0, 4'b0000, 0, 1);
        for (int i = 0; i < 5; i++) begin
            send(1, 4'b1100, 0, 0);
            chk("sat_pulse", match_b, 1);
            chk("sat_flag", sat_b, (i >= 3));
        end
        chk("sat_count_b", count_b, 3);
        chk("sat_sat_b",   sat_b,   1);
        chk("sat_count_a", count_a, 5);
        send(0, 4'b0000, 0, 1);
        chk("sat_clr_count", count_b, 0);
        chk("sat_clr_sat",   sat_b,   0);

        send(1, 4'b1100, 0, 0);
        chk("pre_rst_count", count_a, 1);
        send(1, 4'b0001, 1, 0);
        send(1, 4'b0001, 1, 0);
        send(1, 4'b0000, 1, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_count_a", count_a, 0);
        chk("async_count_b", count_b, 0);
        chk("async_match",   match_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(1, 4'b0000, 1, 0);
        chk("refill_0", match_a, 0);
        seq4 = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            send(1, {3'b000, seq4[3-i]}, 1, 0);
            chk("refill_match", match_a, (i == 3));
        end

        send(1, 4'b1100, 0, 1);
        chk("clr_pri_match", match_a, 0);
        chk("clr_pri_count", count_a, 0);
        for (int i = 0; i < 4; i++) begin
            send(1, {3'b000, seq4[3-i]}, 1, 0);
        end
        chk("tog_pre_hit", match_a, 1);
        send(1, 4'b0000, 0, 0);
        chk("tog_par_miss", match_a, 0);
        for (int i = 0; i < 4; i++) begin
            send(1, {3'b000, seq4[3-i]}, 1, 0);
            chk("tog_fill", match_a, (i == 3));
        end
        chk("tog_count", count_a, 2);

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_match_detector.md
PATTERN_MATCH_DETECTOR -- requirements
Module: pattern_match_detector

Interface
REQ-001 SHALL have parameter W, default 4, meaning data/pattern width in bits, legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 8, meaning match counter width in bits, legal range 1..32.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  meaning in_data is sampled this cycle.
REQ-006 SHALL have port in_data  input  W  meaning the parallel word; bit 0 is the serial bit in serial mode.
REQ-007 SHALL have port mode  input  1  meaning 0 = parallel compare, 1 = serial sequence detect.
REQ-008 SHALL have port cfg_pattern  input  W  meaning the target pattern.
REQ-009 SHALL have port cfg_mask  input  W  meaning per-bit care mask; 1 = compare, 0 = don't care.
REQ-010 SHALL have port clear  input  1  meaning synchronous clear of the counter, flags and serial window.
REQ-011 SHALL have port match  output  1  meaning a registered one-cycle pulse per detected match.
REQ-012 SHALL have port match_count  output  CNT_W  meaning the number of matches since the last reset or clear.
REQ-013 SHALL have port sat  output  1  meaning sticky: match_count has saturated.

Function
REQ-014 Hit condition SHALL be ((X ^ cfg_pattern) & cfg_mask) == 0, evaluated only on a cycle with in_valid=1; cfg_mask all-zero SHALL hit on every qualifying sample.
REQ-015 In parallel mode, X SHALL be in_data; every valid sample SHALL be qualifying.
REQ-016 In serial mode, a valid sample SHALL update window <= {window[W-2:0], in_data[0]}, newest bit at LSB and oldest at MSB; X SHALL be the updated window.
REQ-017 Serial mode SHALL use the FSM FILL -> ARMED: FILL counts valid bits, and on the W-th bit SHALL go to ARMED, with that W-th bit already qualifying; in ARMED every valid bit SHALL be qualifying.
REQ-018 Overlapping serial matches SHALL be detected (no window flush after a hit).
REQ-019 A change of mode, detected against the value registered on the previous cycle, SHALL force FILL, zero the fill count and zero the window; a valid sample on that cycle SHALL be treated as the first bit of a new fill.
REQ-020 match SHALL assert exactly one cycle after the hitting sample edge and SHALL be 0 otherwise; latency SHALL be 1 cycle.
REQ-021 Each hit SHALL increment match_count by 1, saturating at 2^CNT_W-1; a hit while saturated SHALL set sat, and SHALL still pulse match.
REQ-022 sat SHALL remain 1 until reset or clear.
REQ-023 clear SHALL take priority over in_valid on the same cycle: the counter, sat, window and fill count SHALL zero, the FSM SHALL go to FILL, the sample SHALL be discarded, and match SHALL be 0 on the next cycle.
REQ-024 cfg_pattern and cfg_mask SHALL be sampled combinationally at the hit cycle; changing them SHALL NOT disturb the window or the FSM.
REQ-025 in_valid=0 SHALL hold all state unchanged and produce no match.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock, force match=0, match_count=0, sat=0, window=0, fill count=0 and FSM=FILL.
REQ-027 Reset deasserted mid-sequence SHALL require a full W-bit refill before any serial hit.
REQ-028 The first edge after rst_n rises SHALL operate normally.

Verification (W=4, CNT_W=8, cfg_pattern=1100, cfg_mask=1111 unless stated)
REQ-029 Parallel mode: in_data 1100 valid -> match=1 next cycle, count=1; in_data 1101 -> no match, count stays 1.
REQ-030 Mask: cfg_mask=1100, parallel, in_data 1111 -> match; in_data 0111 -> no match.
REQ-031 Serial mode: bits 1,1,0,0,1,1,0,0 -> match after bits 4 and 8, count=2; with cfg_pattern=1010, bits 1,0,1,0,1,0 -> match after bits 4 and 6, covering overlap.
REQ-032 Saturation: CNT_W=2, 5 parallel hits -> count=3, sat=1, five match pulses; then clear -> count=0, sat=0.
REQ-033 Reset mid-serial: bits 1,1,0, then rst_n low mid-cycle -> outputs 0 at once; after release, bit 0 -> no match; next bits 1,1,0,0 -> match after bit 4.
REQ-034 Simultaneous events: clear with a valid hitting sample -> no match, count=0; a mode toggle with a valid bit -> FSM in FILL, that bit counted as fill bit 1.
